// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath: sequences fetch, decode,
// memory, ALU and write-back steps, with a sticky trap state for unknown opcodes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTEX    = 4'd6;
    localparam logic [3:0] S_RTWB    = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd15;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RT:        w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:    w_next = S_RTWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
    end

    // mem_ready-qualified strobes are gated by reset_n so nothing fires while reset is held
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready & reset_n;
                pcwrite = mem_ready & reset_n;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready & reset_n;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign state   = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream with a reactive memory model and a
// scoreboard of per-instruction expectations, followed by directed sequences and reset cases.
module tb_multicycle_ctrl;
    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
    logic       regwrite, regdst, memtoreg, alusrca, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc; int n_ir; int n_pc; int n_rw; int n_mw; int n_br; int n_req; int m2r; int rdst;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    bit         mon_on   = 1'b0;
    logic [5:0] ops[6];

    localparam int N_INSTR = 150;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Expected per-instruction totals, derived from the instruction's step list and wait counts
    function automatic void push_exp(logic [5:0] o, int wf, int wd);
        exp_t e;
        e = '{default: 0};
        e.n_ir = 1; e.n_pc = 1; e.n_req = wf + 1;
        case (o)
            6'b100011: begin e.cyc = 5 + wf + wd; e.n_rw = 1; e.m2r = 1; e.n_req += wd + 1; end
            6'b101011: begin e.cyc = 4 + wf + wd; e.n_mw = wd + 1; e.n_req += wd + 1; end
            6'b000000: begin e.cyc = 4 + wf; e.n_rw = 1; e.rdst = 1; end
            6'b001000: begin e.cyc = 4 + wf; e.n_rw = 1; end
            6'b000100: begin e.cyc = 3 + wf; e.n_br = 1; end
            default:   begin e.cyc = 3 + wf; e.n_pc = 2; end
        endcase
        sb.push_back(e);
    endfunction

    initial begin : monitor
        int cyc, n_ir, n_pc, n_rw, n_mw, n_br, n_req, m2r, rdst;
        exp_t e;
        cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_br = 0; n_req = 0; m2r = 0; rdst = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_on || !reset_n) begin
                cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_br = 0; n_req = 0;
            end else begin
                cyc++;
                n_ir  += int'(irwrite);
                n_pc  += int'(pcwrite);
                n_mw  += int'(memwrite);
                n_br  += int'(branch);
                n_req += int'(mem_req);
                if (regwrite) begin
                    n_rw++;
                    m2r  = int'(memtoreg);
                    rdst = int'(regdst);
                end
                if (instr_done) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rnd_cycles", cyc, e.cyc);
                        chk("rnd_irwrite", n_ir, e.n_ir);
                        chk("rnd_pcwrite", n_pc, e.n_pc);
                        chk("rnd_regwrite", n_rw, e.n_rw);
                        chk("rnd_memwrite", n_mw, e.n_mw);
                        chk("rnd_branch", n_br, e.n_br);
                        chk("rnd_mem_req", n_req, e.n_req);
                        chk("rnd_illegal", int'(illegal), 0);
                        if (e.n_rw != 0) begin
                            chk("rnd_memtoreg", m2r, e.m2r);
                            chk("rnd_regdst", rdst, e.rdst);
                        end
                    end
                    done_cnt++;
                    cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_br = 0; n_req = 0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #3;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_mem_req", int'(mem_req), 1);
        chk("rst_alusrcb", int'(alusrcb), 1);
        chk("rst_zero_ctrls", int'({memwrite, iord, irwrite, pcwrite, branch, regwrite, regdst,
                                    memtoreg, alusrca, instr_done, illegal, pcsrc, aluop}), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : main
        int         wait_cnt, pend_wd, issued, budget, n;
        bit         busy;
        int         lw_seq[5];
        logic [5:0] cur_op;
        lw_seq = '{0, 1, 2, 3, 4};
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        reset_n = 1'b0; op = 6'd0; mem_ready = 1'b1;
        wait_cnt = 0; pend_wd = 0; issued = 0; busy = 1'b0; budget = 0;

        #2;
        chk("init_rst_state", int'(state), 0);
        chk("init_rst_irwrite", int'(irwrite), 0);
        chk("init_rst_mem_req", int'(mem_req), 1);
        @(negedge clk);
        reset_n = 1'b1;
        mon_on  = 1'b1;

        // Random phase: memory model reacts to mem_req/iord, inserting planned wait cycles
        while (done_cnt < N_INSTR && budget < 30000) begin
            if (mem_req && !busy) begin
                busy = 1'b1;
                if (!iord) begin
                    cur_op = ops[$urandom_range(0, 5)];
                    op = cur_op;
                    wait_cnt = $urandom_range(0, 3);
                    pend_wd  = $urandom_range(0, 3);
                    push_exp(cur_op, wait_cnt, pend_wd);
                    issued++;
                end else begin
                    wait_cnt = pend_wd;
                end
            end
            if (mem_req) begin
                mem_ready = (wait_cnt == 0);
                if (wait_cnt == 0) busy = 1'b0;
                else wait_cnt--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            budget++;
        end
        mon_on = 1'b0;
        chk("rnd_completed", done_cnt, N_INSTR);
        chk("rnd_sb_leftover", sb.size(), issued - N_INSTR);

        // LW with zero-wait memory
        apply_reset();
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lw_state", int'(state), lw_seq[i]);
            chk("lw_regwrite", int'(regwrite), int'(i == 4));
            chk("lw_done", int'(instr_done), int'(i == 4));
            @(negedge clk);
        end

        // SW with three wait cycles in MEMWR
        op = 6'b101011; n = 0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = !(i >= 3 && i < 6);
            #1;
            n += int'(memwrite);
            chk("sw_done", int'(instr_done), int'(i == 6));
            @(negedge clk);
        end
        chk("sw_memwrite_cycles", n, 4);

        // Fetch waits then BEQ
        op = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            chk("fetch_wait_state", int'(state), 0);
            chk("fetch_wait_irwrite", int'(irwrite), int'(i == 2));
            chk("fetch_wait_pcwrite", int'(pcwrite), int'(i == 2));
            @(negedge clk);
        end
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("beq_decode", int'(state), 1);
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("beq_state", int'(state), 8);
        chk("beq_branch", int'(branch), 1);
        chk("beq_pcsrc", int'(pcsrc), 1);
        chk("beq_aluop", int'(aluop), 1);
        chk("beq_done", int'(instr_done), 1);
        @(negedge clk);

        // Illegal opcode trap
        op = 6'b111111; mem_ready = 1'b1;
        #1;
        chk("beq_next_fetch", int'(state), 0);
        @(negedge clk);
        #1;
        chk("ill_decode", int'(state), 1);
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("ill_state", int'(state), 15);
            chk("ill_flag", int'(illegal), 1);
            chk("ill_no_writes", int'({mem_req, memwrite, irwrite, pcwrite, regwrite, instr_done}), 0);
            @(negedge clk);
        end
        apply_reset();
        #1;
        chk("ill_cleared_state", int'(state), 0);
        chk("ill_cleared_flag", int'(illegal), 0);
        @(negedge clk);

        // Asynchronous reset during a MEMRD wait
        apply_reset();
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        chk("memrd_wait_state", int'(state), 3);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_regwrite", int'(regwrite), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("held_rst_irwrite", int'(irwrite), 0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_rst_state", int'(state), 0);
            chk("post_rst_regwrite", int'(regwrite), 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: op  input  6  opcode of the instruction register contents.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake completion, sampled on rising clk.
REQ-005 SHALL have port: mem_req  output  1  memory access request.
REQ-006 SHALL have port: memwrite  output  1  memory write enable.
REQ-007 SHALL have port: iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 SHALL have ports: irwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath controls.
REQ-009 SHALL have ports: alusrcb, pcsrc, aluop  output  2 each  ALU operand B select, PC source select, ALU operation class.
REQ-010 SHALL have port: instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-011 SHALL have port: illegal  output  1  sticky illegal-opcode flag.
REQ-012 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-013 SHALL be a Moore FSM; every output SHALL decode from registered state, except that irwrite, pcwrite and instr_done may also use mem_ready.
REQ-014 SHALL use the state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, ILLEGAL=15; codes 12-14 SHALL go to FETCH.
REQ-015 SHALL, in FETCH, assert mem_req with iord=0, alusrca=0, alusrcb=01, aluop=00 and pcsrc=00.
- FETCH SHALL hold while mem_ready=0.
- When mem_ready=1: irwrite=1, pcwrite=1 for that cycle only, then go to DECODE.
REQ-016 SHALL, in DECODE, drive alusrca=0, alusrcb=11, aluop=00, and SHALL branch on op.
- 100011 or 101011 -> MEMADR.
- 000000 -> RTEX.
- 000100 -> BEQEX.
- 001000 -> ADDIEX.
- 000010 -> JEX.
- Any other opcode -> ILLEGAL.
REQ-017 SHALL, in MEMADR, drive alusrca=1, alusrcb=10, aluop=00, then go to MEMRD if op=100011, else MEMWR.
REQ-018 SHALL, in MEMRD, drive mem_req=1, iord=1, and hold until mem_ready=1, then go to MEMWB.
REQ-019 SHALL, in MEMWB, drive regwrite=1, memtoreg=1, regdst=0, instr_done=1, then go to FETCH.
REQ-020 SHALL, in MEMWR, drive mem_req=1, iord=1, memwrite=1 for every wait cycle.
- Hold until mem_ready=1; instr_done=1 in that cycle; then go to FETCH.
REQ-021 SHALL, in RTEX, drive alusrca=1, alusrcb=00, aluop=10 -> RTWB.
- In RTWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1 -> FETCH.
REQ-022 SHALL, in BEQEX, drive alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01, instr_done=1 -> FETCH.
REQ-023 SHALL, in ADDIEX, drive alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- In ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1 -> FETCH.
REQ-024 SHALL, in JEX, drive pcsrc=10, pcwrite=1, instr_done=1 -> FETCH.
REQ-025 SHALL, in ILLEGAL, set illegal=1 and keep all write enables and mem_req at 0.
- ILLEGAL SHALL stay there until reset.
REQ-026 SHALL drive every control not listed for a state to 0; no output SHALL ever be X.
REQ-027 SHALL ignore mem_ready in states that do not assert mem_req.
REQ-028 SHALL give these cycle counts with zero-wait memory:
- LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds 1.

Reset
REQ-029 SHALL, while reset_n=0 (asynchronously), force state=FETCH, illegal=0, and every output 0 except mem_req=1, alusrcb=01.
REQ-030 SHALL, when reset is asserted mid-instruction (including mid memory wait), abandon the instruction with no further write enables.
- The first cycle after reset_n rises SHALL be FETCH.

Verification
REQ-031 SHALL check: op=100011, mem_ready=1 always -> states 0,1,2,3,4; regwrite=1 and instr_done=1 only in cycle 5.
REQ-032 SHALL check: op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles; instr_done only on the 4th.
REQ-033 SHALL check: FETCH with mem_ready low 2 cycles then high -> irwrite/pcwrite high exactly 1 cycle, on the 3rd FETCH cycle.
REQ-034 SHALL check: op=000100 -> states 0,1,8; branch=1, pcsrc=01, aluop=01 in state 8; next state 0.
REQ-035 SHALL check: op=111111 -> DECODE then ILLEGAL; illegal=1 and no write enables for 10+ cycles; reset_n pulse clears illegal and returns state to 0.
REQ-036 SHALL check: reset_n low asynchronously during MEMRD wait -> state=0 immediately, without a clk edge; no regwrite pulse afterwards.
